data_from_transfer: RTL and testbench
=====================================

Name: data_from_transfer

Overview:
- Receive-side counterpart of the 4-byte score packet sender.
- Pops bytes from a UART RX FIFO and reassembles packets in the order {board_ID, points[23:16], points[15:8], points[7:0]}.
- Presents the remote board ID and 24-bit points with a one-cycle valid strobe.
- Sits between the UART RX FIFO and the game/score logic; an inter-byte timeout recovers framing after lost bytes.

Parameters:
- TIMEOUT_CYCLES, 100000, max idle clk cycles between captured bytes of one packet before the partial packet is discarded (>= 4).

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- board_ID  input  8  own board ID; used only by the optional filter
- rx_empty  input  1  RX FIFO empty flag
- rx_data  input  8  RX FIFO read data, valid the cycle after rd_en
- rd_en  output  1  registered one-cycle FIFO pop strobe
- rx_board_ID  output  8  ID byte of last accepted packet
- rx_points  output  24  points of last accepted packet
- pkt_valid  output  1  one-cycle pulse: rx_board_ID/rx_points just updated
- timeout_err  output  1  one-cycle pulse: partial packet dropped on timeout

Behaviour:
- Reset (rst=0, async): rd_en=0, pkt_valid=0, timeout_err=0, rx_board_ID=0, rx_points=0. Internal state cleared: byte_idx=0, cap_pending=0, timeout counter=0, shadow byte registers=0.
- Reset mid-packet discards all partial data; no in-flight capture is honoured after release.
- Read control:
  - rd_en is asserted for exactly one cycle when rx_empty=0, rd_en=0 and cap_pending=0.
  - cap_pending is set in the cycle after rd_en. In that cycle rx_data is registered into the slot selected by byte_idx, then cap_pending clears.
  - Consequently at most one pop per 3 cycles, and never a pop on empty.
- Byte slots:
  - idx0 = ID.
  - idx1 -> points[23:16], idx2 -> [15:8], idx3 -> [7:0] (big-endian, matches the sender).
- idx0 capture:
  - If rx_data = 8'h00, the byte is consumed and discarded; byte_idx stays 0 (resync on invalid ID).
  - Otherwise the ID is stored and byte_idx becomes 1.
- idx1/idx2 capture: store the byte; byte_idx increments.
- idx3 capture: the packet completes and byte_idx returns to 0. In the following cycle rx_board_ID and rx_points are loaded and pkt_valid=1 for one cycle.
- Latency: rd_en for the last byte in cycle N; rx_data sampled at the end of N+1; outputs and pkt_valid valid in N+2.
- Outputs hold their values between packets; pkt_valid is never high two consecutive cycles.
- Timeout:
  - The counter runs only while byte_idx != 0.
  - It clears on every byte capture and when byte_idx = 0.
  - When the counter reaches TIMEOUT_CYCLES-1 with no capture that cycle: byte_idx -> 0, partial bytes are dropped, timeout_err=1 for one cycle, outputs are unchanged.
- Simultaneous events:
  - Capture in the same cycle as timeout expiry: capture wins. The byte is accepted, the counter clears, no timeout_err.
  - A read already issued (rd_en high) when timeout fires: its byte is captured next cycle as idx0.
- rx_empty asserting mid-packet only stalls; byte_idx and stored bytes are held.

Optional Feature:
- Macro: DATA_FROM_TRANSFER_ID_FILTER_EN.
- Defined: a completed packet whose ID byte equals board_ID (own echo) is dropped. No pkt_valid; outputs unchanged; byte_idx returns to 0 normally.
- Undefined: every completed packet with a nonzero ID produces pkt_valid; the board_ID input is unused.

Test Plan:
- Reset, then FIFO holds 8'h03,8'h12,8'h34,8'h56 -> exactly 4 rd_en pulses, none while empty; pkt_valid once with rx_board_ID=8'h03, rx_points=24'h123456.
- FIFO holds 8'h00 then 8'h05,8'hAA,8'hBB,8'hCC -> zero byte consumed and discarded; single pkt_valid with 8'h05/24'hAABBCC.
- TIMEOUT_CYCLES=16; send 8'h07,8'h11, then stay empty for 20 cycles, then 8'h09,8'h01,8'h02,8'h03 -> timeout_err pulse 16 cycles after the 8'h11 capture; next pkt_valid gives 8'h09/24'h010203; outputs unchanged before it.
- Back-to-back packets (8'h01,00,00,0A)(8'h02,00,00,0B) in FIFO -> two pkt_valid pulses, separated by >= 12 cycles, values 8'h01/24'h00000A then 8'h02/24'h00000B.
- rst=0 asserted after 2 bytes of a packet, then released, then a full packet 8'h04,8'h00,8'h00,8'h01 -> all outputs 0 during reset; one pkt_valid with 8'h04/24'h000001 and no mix of old bytes.
- With DATA_FROM_TRANSFER_ID_FILTER_EN and board_ID=8'h03: packets with IDs 8'h03 then 8'h06 -> no pkt_valid for 8'h03; pkt_valid for 8'h06 only.

Source files
------------

// File: rtl/data_from_transfer.sv
// data_from_transfer: pops UART RX FIFO bytes and reassembles {ID, points[23:16], points[15:8], points[7:0]} packets.
// Optional own-echo filter: define DATA_FROM_TRANSFER_ID_FILTER_EN.
module data_from_transfer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  board_ID,
  input  logic        rx_empty,
  input  logic [7:0]  rx_data,
  output logic        rd_en,
  output logic [7:0]  rx_board_ID,
  output logic [23:0] rx_points,
  output logic        pkt_valid,
  output logic        timeout_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT_CYCLES - 1);
  logic [1:0]    byte_idx;
  logic          cap_pending;
  logic [CW-1:0] cnt;
  logic [7:0]    id_q, p_hi, p_mid;
  logic          expire, accept;
  // A capture in the expiry cycle takes priority over the timeout.
  assign expire = (byte_idx != 2'd0) && (cnt == T_MAX) && !cap_pending;
`ifdef DATA_FROM_TRANSFER_ID_FILTER_EN
  assign accept = id_q != board_ID;
`else
  logic unused_board_id;
  assign unused_board_id = ^board_ID;
  assign accept = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_en       <= 1'b0;
      cap_pending <= 1'b0;
      pkt_valid   <= 1'b0;
      timeout_err <= 1'b0;
      rx_board_ID <= '0;
      rx_points   <= '0;
      byte_idx    <= '0;
      cnt         <= '0;
      id_q        <= '0;
      p_hi        <= '0;
      p_mid       <= '0;
    end else begin
      rd_en       <= !rx_empty && !rd_en && !cap_pending;
      cap_pending <= rd_en;
      pkt_valid   <= 1'b0;
      timeout_err <= expire;
      cnt         <= (byte_idx == 2'd0 || cap_pending || expire) ? '0 : cnt + 1'b1;
      if (cap_pending) begin
        // A zero ID byte is dropped so the stream can resync on the next real ID.
        byte_idx <= (byte_idx == 2'd0 && rx_data == 8'h00) ? 2'd0 : byte_idx + 2'd1;
        if (byte_idx == 2'd0 && rx_data != 8'h00) id_q <= rx_data;
        if (byte_idx == 2'd1) p_hi <= rx_data;
        if (byte_idx == 2'd2) p_mid <= rx_data;
        if (byte_idx == 2'd3 && accept) begin
          rx_board_ID <= id_q;
          rx_points   <= {p_hi, p_mid, rx_data};
          pkt_valid   <= 1'b1;
        end
      end else if (expire) begin
        byte_idx <= 2'd0;
      end
    end
  end
endmodule

// File: tb/tb_data_from_transfer.sv
// tb_data_from_transfer: directed bench with a FIFO model and output monitor for data_from_transfer.
module tb_data_from_transfer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  board_ID = 8'hF0;
  logic        rx_empty;
  logic [7:0]  rx_data = 8'h00;
  logic        rd_en;
  logic [7:0]  rx_board_ID;
  logic [23:0] rx_points;
  logic        pkt_valid;
  logic        timeout_err;

  data_from_transfer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .board_ID(board_ID), .rx_empty(rx_empty), .rx_data(rx_data),
    .rd_en(rd_en), .rx_board_ID(rx_board_ID), .rx_points(rx_points),
    .pkt_valid(pkt_valid), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:255];
  logic [7:0] wp = 8'd0;
  logic [7:0] rp = 8'd0;
  assign rx_empty = (wp == rp);

  always @(posedge clk) begin
    if (rd_en) begin
      rx_data <= mem[rp];
      rp <= rp + 8'd1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nrd = 0, rd_bad = 0, npkt = 0, nte = 0, dbl = 0, last_rd = 0, te_cyc = 0;
  logic pv_prev = 1'b0;
  logic [7:0]  pid  [0:15];
  logic [23:0] ppts [0:15];
  int          pcyc [0:15];

  always @(negedge clk) begin
    if (rd_en) begin
      nrd <= nrd + 1;
      last_rd <= cyc;
      if (rx_empty) rd_bad <= rd_bad + 1;
    end
    if (pkt_valid) begin
      pid[npkt[3:0]]  <= rx_board_ID;
      ppts[npkt[3:0]] <= rx_points;
      pcyc[npkt[3:0]] <= cyc;
      npkt <= npkt + 1;
    end
    if (pkt_valid && pv_prev) dbl <= dbl + 1;
    pv_prev <= pkt_valid;
    if (timeout_err) begin
      nte <= nte + 1;
      te_cyc <= cyc;
    end
  end

  int nvec = 0, nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp] = b;
    wp = wp + 8'd1;
  endtask

  task automatic wait_pkts(input int n, input int budget);
    for (int i = 0; i < budget && npkt < n; i++) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, {31'd0, rd_en}, 32'd0);
    chk({tag, "_pkt_valid"}, {31'd0, pkt_valid}, 32'd0);
    chk({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
    chk({tag, "_rx_board_ID"}, {24'd0, rx_board_ID}, 32'd0);
    chk({tag, "_rx_points"}, {8'd0, rx_points}, 32'd0);
  endtask

  initial begin
    // Reset with a full packet already waiting in the FIFO
    push(8'h03); push(8'h12); push(8'h34); push(8'h56);
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    wait_pkts(1, 100);
    repeat (5) @(negedge clk);
    chk("p1_count", npkt, 1);
    chk("p1_id", {24'd0, pid[0]}, 32'h03);
    chk("p1_points", {8'd0, ppts[0]}, 32'h123456);
    chk("p1_rd_pulses", nrd, 4);
    chk("p1_rd_on_empty", rd_bad, 0);

    // Leading zero byte is consumed and discarded
    push(8'h00); push(8'h05); push(8'hAA); push(8'hBB); push(8'hCC);
    wait_pkts(2, 100);
    repeat (5) @(negedge clk);
    chk("p2_count", npkt, 2);
    chk("p2_id", {24'd0, pid[1]}, 32'h05);
    chk("p2_points", {8'd0, ppts[1]}, 32'hAABBCC);
    chk("p2_rd_pulses", nrd, 9);

    // Partial packet then idle: timeout drops it
    push(8'h07); push(8'h11);
    repeat (40) @(negedge clk);
    chk("to_count", nte, 1);
    chk("to_delay", te_cyc - last_rd, 18);
    chk("to_pkt_count", npkt, 2);
    chk("to_id_held", {24'd0, rx_board_ID}, 32'h05);
    chk("to_points_held", {8'd0, rx_points}, 32'hAABBCC);
    push(8'h09); push(8'h01); push(8'h02); push(8'h03);
    wait_pkts(3, 100);
    repeat (2) @(negedge clk);
    chk("p3_id", {24'd0, pid[2]}, 32'h09);
    chk("p3_points", {8'd0, ppts[2]}, 32'h010203);

    // Back-to-back packets
    push(8'h01); push(8'h00); push(8'h00); push(8'h0A);
    push(8'h02); push(8'h00); push(8'h00); push(8'h0B);
    wait_pkts(5, 200);
    repeat (2) @(negedge clk);
    chk("b2b_count", npkt, 5);
    chk("b2b_id0", {24'd0, pid[3]}, 32'h01);
    chk("b2b_pts0", {8'd0, ppts[3]}, 32'h00000A);
    chk("b2b_id1", {24'd0, pid[4]}, 32'h02);
    chk("b2b_pts1", {8'd0, ppts[4]}, 32'h00000B);
    chk("b2b_gap_ge12", {31'd0, (pcyc[4] - pcyc[3]) >= 12}, 32'd1);

    // Reset in the middle of a packet
    push(8'h0E); push(8'h77);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b1;
    push(8'h04); push(8'h00); push(8'h00); push(8'h01);
    wait_pkts(6, 100);
    repeat (5) @(negedge clk);
    chk("mr_count", npkt, 6);
    chk("mr_id", {24'd0, pid[5]}, 32'h04);
    chk("mr_points", {8'd0, ppts[5]}, 32'h000001);

`ifdef DATA_FROM_TRANSFER_ID_FILTER_EN
    board_ID = 8'h03;
    push(8'h03); push(8'h11); push(8'h22); push(8'h33);
    push(8'h06); push(8'h44); push(8'h55); push(8'h66);
    wait_pkts(7, 200);
    repeat (20) @(negedge clk);
    chk("filt_count", npkt, 7);
    chk("filt_id", {24'd0, pid[6]}, 32'h06);
    chk("filt_points", {8'd0, ppts[6]}, 32'h445566);
`endif

    chk("no_double_valid", dbl, 0);
    chk("total_timeouts", nte, 1);
    chk("rd_on_empty_total", rd_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
